// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 640x480@60 geometry, derived totals and sync windows.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned FRAME_W = 16;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_CLK_DIV   = 4;

  localparam int unsigned H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  localparam int unsigned X_MAX = H_TOTAL - 1;
  localparam int unsigned Y_MAX = V_TOTAL - 1;

endpackage

// File: rtl/vga_tick_div.sv
// Divide-by-CLK_DIV counter producing a registered one-clk enable after each wrap.
module vga_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == CNT_LAST);
      div_cnt <= (div_cnt == CNT_LAST) ? '0 : div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel tick, x/y counters, active-low syncs and video_on.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV
) (
  input  logic               clk,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] frame_cnt
`endif
);

  localparam int unsigned H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] X_VIS    = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] Y_VIS    = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;

  vga_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .tick  (p_tick)
  );

  // Next raster position; x and y wrap together on the last pixel of a line.
  always_comb begin
    x_next = x;
    y_next = y;
    if (p_tick) begin
      if (x == X_LAST) begin
        x_next = '0;
        y_next = (y == Y_LAST) ? '0 : y + COORD_W'(1);
      end else begin
        x_next = x + COORD_W'(1);
      end
    end
  end

  // Syncs are decoded from next-state coordinates so they move on the same edge as x/y.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x     <= '0;
      y     <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      x     <= x_next;
      y     <= y_next;
      hsync <= !((x_next >= HS_START) && (x_next <= HS_END));
      vsync <= !((y_next >= VS_START) && (y_next <= VS_END));
    end
  end

  assign video_on = reset && (x < X_VIS) && (y < Y_VIS);

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (p_tick && (x == X_LAST) && (y == Y_LAST)) begin
      frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing vector table plus a reduced-geometry instance
// checked every clk against an arithmetic raster model under random resets.
module tb_vga_sync_gen;

  localparam int S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VD = 6, S_VF = 1, S_VS = 2, S_VB = 2;
  localparam int S_DIV = 3;
  localparam int S_HT = S_HD + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VD + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_HT * S_VT;

  typedef struct {
    int c;
    int x;
    int y;
    bit hs;
    bit vs;
    bit vo;
    bit pt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_hs, d_vs, d_vo, d_pt;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_vo, s_pt;
  logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] d_fc, s_fc;
  int          fc_off = 0;
`endif

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  vga_sync_gen u_dut (
    .clk      (clk),
    .reset    (reset),
    .hsync    (d_hs),
    .vsync    (d_vs),
    .video_on (d_vo),
    .p_tick   (d_pt),
    .x        (d_x),
    .y        (d_y)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt (d_fc)
`endif
  );

  vga_sync_gen #(
    .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
    .CLK_DIV   (S_DIV)
  ) u_small (
    .clk      (clk),
    .reset    (reset),
    .hsync    (s_hs),
    .vsync    (s_vs),
    .video_on (s_vo),
    .p_tick   (s_pt),
    .x        (s_x),
    .y        (s_y)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt (s_fc)
`endif
  );

  always #5 clk = ~clk;

  // Clocks since the last edge that sampled reset low.
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [23:0] pack(int px, int py, bit hs, bit vs, bit vo, bit pt);
    return {10'(px), 10'(py), hs, vs, vo, pt};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Raster position follows from the number of ticks since release: one per S_DIV clks.
  task automatic check_small();
    int n, ex, ey;
    bit ehs, evs, evo, ept;
    n   = (cyc == 0) ? 0 : (cyc - 1) / S_DIV;
    ex  = n % S_HT;
    ey  = (n / S_HT) % S_VT;
    ehs = !(ex >= S_HD + S_HF && ex <= S_HD + S_HF + S_HS - 1);
    evs = !(ey >= S_VD + S_VF && ey <= S_VD + S_VF + S_VS - 1);
    evo = reset && (ex < S_HD) && (ey < S_VD);
    ept = (cyc >= S_DIV) && (cyc % S_DIV == 0);
    chk("small_raster", 32'(pack(int'(s_x), int'(s_y), s_hs, s_vs, s_vo, s_pt)),
        32'(pack(ex, ey, ehs, evs, evo, ept)));
`ifdef VGA_FRAME_CNT_EN
    if (cyc == 0) fc_off = 0;
    chk("small_frame_cnt", 32'(s_fc), 32'(16'(n / S_FRAME + fc_off)));
`endif
  endtask

  task automatic step();
    @(negedge clk);
    check_small();
  endtask

  initial begin
    vec_t tbl[13];
    int   hits, runs, vs_low, last_start;
    bit   hit, prev_hit;

    // Default 640x480 timing, cycle counted from reset release.
    tbl[0]  = '{1,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{3,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{4,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{5,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{8,    1,   0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{2557, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{2561, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{2621, 655, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{2625, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{3005, 751, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{3009, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{3197, 799, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{3201, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_hold", 32'(pack(int'(d_x), int'(d_y), d_hs, d_vs, d_vo, d_pt)),
          32'(pack(0, 0, 1'b1, 1'b1, 1'b0, 1'b0)));
    end
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      while (cyc < tbl[i].c) step();
      chk($sformatf("vec%0d", i), 32'(pack(int'(d_x), int'(d_y), d_hs, d_vs, d_vo, d_pt)),
          32'(pack(tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].vo, tbl[i].pt)));
    end

    // One-clk reset in the middle of line 1.
    while (cyc < 4401) step();
    chk("pre_reset_xy", 32'({d_x, d_y}), 32'({10'd300, 10'd1}));
    reset = 1'b0;
    #1;
    chk("reset_vo_gate", 32'(d_vo), 32'(0));
    step();
    chk("mid_reset", 32'(pack(int'(d_x), int'(d_y), d_hs, d_vs, d_vo, d_pt)),
        32'(pack(0, 0, 1'b1, 1'b1, 1'b0, 1'b0)));
    reset = 1'b1;
    repeat (4) begin
      step();
      chk("restart_ptick", 32'(d_pt), 32'(cyc == 4));
    end

    // Three reduced frames: refresh point (y == V_DISPLAY+1, x == 0) and vsync width.
    hits = 0; runs = 0; vs_low = 0; last_start = -1; prev_hit = 1'b0;
    while (cyc < 1495) begin
      step();
      hit = (s_y == 10'(S_VD + 1)) && (s_x == 10'd0);
      if (hit) hits++;
      if (!s_vs) vs_low++;
      if (hit && !prev_hit) begin
        if (last_start >= 0) chk("refresh_gap", 32'(cyc - last_start), 32'(S_FRAME * S_DIV));
        last_start = cyc;
        runs++;
      end
      prev_hit = hit;
    end
    chk("refresh_clks", 32'(hits), 32'(3 * S_DIV));
    chk("refresh_runs", 32'(runs), 32'(3));
    chk("vsync_low_clks", 32'(vs_low), 32'(3 * S_VS * S_HT * S_DIV));

`ifdef VGA_FRAME_CNT_EN
    fc_off = 32'hFFFF - ((cyc - 1) / S_DIV) / S_FRAME;
    force u_small.frame_cnt = 16'hFFFF;
    step();
    release u_small.frame_cnt;
    repeat (700) step();
    chk("frame_cnt_wrap", 32'(s_fc), 32'(0));
`endif

    // Random run lengths broken by random-width reset pulses.
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(700, 20)) step();
      reset = 1'b0;
      repeat ($urandom_range(3, 1)) step();
      reset = 1'b1;
    end
    repeat (50) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
